inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Read-side initiator for the instruction memory.
- Owns the program counter and drives the memory's combinational read address every cycle.
- Captures {pc, instruction} pairs into a small buffer and hands them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute and flushes stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into fetch PC on reset
DEPTH, 2, fetch buffer entries (power of two, >= 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_raddr_o  output  `ADDR_LEN  word index to instruction memory = fetch_pc >> 2, zero-extended
imem_rdata_i  input  `INST_LEN  combinational read data for imem_raddr_o, same cycle
redirect_i  input  1  redirect request from execute
redirect_pc_i  input  32  new byte PC for redirect
inst_valid_o  output  1  buffer head is valid
inst_ready_i  input  1  decode accepts head this cycle
inst_o  output  `INST_LEN  head instruction
pc_o  output  32  head byte PC
pred_taken_o  output  1  head was steered by static JAL prediction

Behaviour:
- Reset (async, dominant over all inputs):
  - fetch_pc = RESET_PC; buffer empty; count = 0.
  - Outputs: inst_valid_o = 0, inst_o = 0, pc_o = 0, pred_taken_o = 0.
  - imem_raddr_o = RESET_PC >> 2.
- Fetch latency:
  - Memory read is combinational, so a fetch completes in the cycle it is issued.
  - A pushed entry is visible on inst_valid_o the next cycle. Redirect-to-valid latency is 1 cycle.
- Push condition: !redirect_i && (count < DEPTH || (count == DEPTH && pop)).
- On push:
  - Write {fetch_pc, imem_rdata_i, pred} at the tail.
  - fetch_pc <= next_pc, where next_pc = fetch_pc + 4 (mod 2^32, so 0xFFFF_FFFC wraps to 0).
- No push (buffer full without pop): fetch_pc and imem_raddr_o hold.
- Pop: inst_valid_o && inst_ready_i; the head advances.
- Push and pop in the same cycle: count is unchanged, ordering is preserved. When empty, a push followed by a pop on the next cycle gives 1 instruction/cycle sustained throughput.
- Redirect:
  - Clears the buffer (count = 0, inst_valid_o = 0 next cycle) and loads fetch_pc <= redirect_pc_i.
  - No push that cycle; redirect wins over push.
  - A coincident pop is also void: decode must treat that cycle's head as squashed, since execute drives both.
- Back-to-back redirects: the last one wins. Each one flushes and reloads.
- Misaligned redirect_pc_i: bits [1:0] are ignored for addressing, but pc_o carries the full value.
- Outputs are registered from buffer storage. inst_o and pc_o are don't-care while inst_valid_o = 0; the bench does not check them.

Optional Feature:
IF_JAL_PREDICT_EN
- Defined:
  - On push, if imem_rdata_i[6:0] == 7'b1101111 (JAL), next_pc = fetch_pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - The entry's pred bit = 1. Wrap-around is modulo 2^32.
- Undefined: next_pc is always fetch_pc + 4, and pred_taken_o is tied 0.
- The port list is identical in both builds.

Decomposition:
- Shared defines file: ADDR_LEN and INST_LEN widths, OPC_JAL opcode constant, reset PC constant.
- One natural sub-module: if_fifo, a DEPTH-entry synchronous FIFO with flush, same-cycle push/pop and async reset. The top holds the PC, next-PC logic and push gating.

Test Plan:
- Reset with RESET_PC = 0x100, mem[0x40..0x42] = A, B, C, inst_ready_i = 1 -> imem_raddr_o = 0x40 during reset; after release, A @0x100, B @0x104, C @0x108 on consecutive cycles.
- inst_ready_i = 0 for 5 cycles -> count saturates at 2, imem_raddr_o holds at the third word. On ready = 1, the stream continues with no loss or duplication.
- Redirect to 0x200 while the buffer holds 2 entries, with ready = 1 the same cycle -> next cycle inst_valid_o = 0; following cycle head = mem[0x80] @0x200. The old entries never appear.
- fetch_pc = 0xFFFF_FFFC -> next pushed pc_o = 0x0000_0000.
- Async rst asserted mid-cycle with valid = 1 -> inst_valid_o drops immediately without a clock edge; fetch restarts at RESET_PC.
- With IF_JAL_PREDICT_EN: instruction 0x0100006F (JAL +16) at 0x100 -> next entry pc_o = 0x110, and the JAL entry has pred_taken_o = 1. Without the macro: next pc_o = 0x104, pred_taken_o = 0.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit_pkg
// Description : Widths, opcode constants, fetch-buffer entry type and the
//               J-type immediate decoder used by the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_unit_pkg;

    localparam int          ADDR_LEN         = 32;   // imem word-index width
    localparam int          INST_LEN         = 32;   // instruction width
    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One fetch-buffer slot: byte PC, raw instruction, predicted-taken flag.
    typedef struct packed {
        logic [31:0]         pc;
        logic [INST_LEN-1:0] inst;
        logic                pred;
    } if_entry_t;

    // Sign-extended JAL byte offset.
    function automatic logic [31:0] jal_imm(input logic [INST_LEN-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage : inst_fetch_unit_pkg
`default_nettype wire

// File: rtl/inst_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : if_fifo
// Description : DEPTH-entry synchronous FIFO of fetch entries with flush,
//               same-cycle push/pop and asynchronous reset. The head entry is
//               read straight from storage, so the outputs are registered.
// Ports       : clk, rst        - clock, async active-high reset
//               flush_i         - drop all entries (dominates push/pop)
//               push_i, data_i  - write data_i at the tail
//               pop_i           - advance the head (ignored when empty)
//               valid_o, head_o - head entry and its valid flag
//               full_o          - all DEPTH slots occupied
// Revision    : 1.0 - initial release
// ============================================================================
module if_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush_i,
    input  logic      push_i,
    input  if_entry_t data_i,
    input  logic      pop_i,
    output logic      valid_o,
    output if_entry_t head_o,
    output logic      full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // A push into a full FIFO is only requested alongside a pop; the
            // slot being overwritten is the head that leaves this cycle.
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

endmodule : if_fifo
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Instruction fetch unit. Owns the fetch PC, drives the
//               combinational instruction-memory read address every cycle,
//               buffers {pc, inst, pred} entries and presents them to decode
//               over valid/ready. Redirects flush the buffer and reload PC.
// Config      : IF_JAL_PREDICT_EN - when defined, a fetched JAL steers the
//               next fetch to its target and marks the entry pred_taken.
// Ports       : clk, rst                 - clock, async active-high reset
//               imem_raddr_o, imem_rdata_i - memory word index / read data
//               redirect_i, redirect_pc_i  - redirect from execute
//               inst_valid_o, inst_ready_i - decode handshake
//               inst_o, pc_o, pred_taken_o - head entry
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_LEN-1:0] imem_raddr_o,
    input  logic [INST_LEN-1:0] imem_rdata_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [INST_LEN-1:0] inst_o,
    output logic [31:0]         pc_o,
    output logic                pred_taken_o
);

    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] next_pc;
    logic        pred;
    logic        push;
    logic        pop;
    logic        fifo_full;
    if_entry_t   push_entry;
    if_entry_t   head;

    // Word index; low two PC bits never reach the memory.
    assign imem_raddr_o = ADDR_LEN'(fetch_pc_q >> 2);

    always_comb begin
        next_pc = fetch_pc_q + 32'd4;
        pred    = 1'b0;
`ifdef IF_JAL_PREDICT_EN
        if (imem_rdata_i[6:0] == OPC_JAL) begin
            next_pc = fetch_pc_q + jal_imm(imem_rdata_i);
            pred    = 1'b1;
        end
`endif
    end

    // A pop on the redirect cycle is harmless: the flush empties the FIFO.
    assign pop  = inst_valid_o && inst_ready_i;
    assign push = !redirect_i && (!fifo_full || pop);

    assign push_entry = '{pc: fetch_pc_q, inst: imem_rdata_i, pred: pred};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
        end else if (push) begin
            fetch_pc_d = next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .valid_o (inst_valid_o),
        .head_o  (head),
        .full_o  (fifo_full)
    );

    assign inst_o       = head.inst;
    assign pc_o         = head.pc;
    assign pred_taken_o = head.pred;   // always stored as 0 without prediction

endmodule : inst_fetch_unit
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Self-checking bench for inst_fetch_unit: directed vector
//               table, randomized traffic against a queue-based model,
//               asynchronous reset and JAL prediction sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;
`ifdef IF_JAL_PREDICT_EN
    localparam bit          JAL_EN = 1'b1;
`else
    localparam bit          JAL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;

    int checks = 0;
    int errors = 0;
    bit jal_mode = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_raddr_o  (imem_raddr),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .inst_valid_o  (inst_valid),
        .inst_ready_i  (inst_ready),
        .inst_o        (inst),
        .pc_o          (pc),
        .pred_taken_o  (pred_taken)
    );

    // Memory contents: never a JAL unless jal_mode plants one at word 0x40.
    function automatic logic [31:0] mem_word(input logic [31:0] widx);
        if (jal_mode && widx == 32'h40) return 32'h0100_006F;
        return {widx[24:0] ^ 25'h0ABCDEF, 7'h13};
    endfunction

    assign imem_rdata = mem_word(imem_raddr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          pred;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;

    task automatic model_reset();
        mq.delete();
        m_pc = RST_PC;
    endtask

    task automatic model_step(input bit red, input logic [31:0] rpc, input bit rdy);
        bit          popped;
        ent_t        e;
        logic [31:0] w;
        logic [31:0] off;
        popped = (mq.size() > 0) && rdy;
        if (red) begin
            mq.delete();
            m_pc = rpc;
        end else begin
            if (popped) void'(mq.pop_front());
            if (mq.size() < DEPTH) begin
                w      = mem_word(m_pc >> 2);
                e.pc   = m_pc;
                e.inst = w;
                e.pred = JAL_EN && (w[6:0] == 7'b1101111);
                mq.push_back(e);
                if (e.pred) begin
                    off  = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
                    m_pc = m_pc + off;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic model_check();
        chk("valid", {31'b0, inst_valid}, {31'b0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk("pc", pc, mq[0].pc);
            chk("inst", inst, mq[0].inst);
            chk("pred", {31'b0, pred_taken}, {31'b0, mq[0].pred});
        end
        chk("raddr", imem_raddr, m_pc >> 2);
    endtask

    // Apply inputs for one cycle: called at negedge, returns at next negedge.
    task automatic cycle(input bit red, input logic [31:0] rpc, input bit rdy);
        redirect    = red;
        redirect_pc = rpc;
        inst_ready  = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        redirect   = 1'b0;
        inst_ready = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_raddr", imem_raddr, RST_PC >> 2);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pred", {31'b0, pred_taken}, 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          red;
        logic [31:0] rpc;
        bit          rdy;
        bit          ev;      // expected inst_valid before this cycle's edge
        logic [31:0] epc;     // expected head pc when ev
        logic [31:0] eraddr;  // expected imem_raddr
    } vec_t;

    vec_t vt[17];

    initial begin
        vt[0]  = '{0, 32'h0,         1, 0, 32'h0,         32'h40};
        vt[1]  = '{0, 32'h0,         1, 1, 32'h100,       32'h41};
        vt[2]  = '{0, 32'h0,         1, 1, 32'h104,       32'h42};
        vt[3]  = '{0, 32'h0,         1, 1, 32'h108,       32'h43};
        vt[4]  = '{0, 32'h0,         0, 1, 32'h10C,       32'h44};
        vt[5]  = '{0, 32'h0,         0, 1, 32'h10C,       32'h45};
        vt[6]  = '{0, 32'h0,         0, 1, 32'h10C,       32'h45};
        vt[7]  = '{0, 32'h0,         0, 1, 32'h10C,       32'h45};
        vt[8]  = '{0, 32'h0,         0, 1, 32'h10C,       32'h45};
        vt[9]  = '{0, 32'h0,         1, 1, 32'h10C,       32'h45};
        vt[10] = '{0, 32'h0,         1, 1, 32'h110,       32'h46};
        vt[11] = '{1, 32'h200,       1, 1, 32'h114,       32'h47};
        vt[12] = '{0, 32'h0,         1, 0, 32'h0,         32'h80};
        vt[13] = '{1, 32'hFFFF_FFFC, 1, 1, 32'h200,       32'h81};
        vt[14] = '{0, 32'h0,         1, 0, 32'h0,         32'h3FFF_FFFF};
        vt[15] = '{0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0};
        vt[16] = '{0, 32'h0,         1, 1, 32'h0,         32'h1};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 17; i++) begin
            chk($sformatf("vec%0d_valid", i), {31'b0, inst_valid}, {31'b0, vt[i].ev});
            chk($sformatf("vec%0d_raddr", i), imem_raddr, vt[i].eraddr);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_pc", i), pc, vt[i].epc);
                chk($sformatf("vec%0d_inst", i), inst, mem_word(vt[i].epc >> 2));
                chk($sformatf("vec%0d_pred", i), {31'b0, pred_taken}, 32'd0);
            end
            cycle(vt[i].red, vt[i].rpc, vt[i].rdy);
        end

        // ---------------- randomized traffic ----------------
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit          r_red;
            bit          r_rdy;
            logic [31:0] r_pc;
            r_red = ($urandom_range(0, 7) == 0);
            r_rdy = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 2))
                0:       r_pc = $urandom;
                1:       r_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: r_pc = {20'h0, 12'($urandom)};
            endcase
            model_check();
            cycle(r_red, r_pc, r_rdy);
            model_step(r_red, r_pc, r_rdy);
        end

        // ---------------- async reset mid-cycle ----------------
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            model_step(1'b0, 32'h0, 1'b0);
        end
        model_check();   // buffer is full and valid here
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, inst_valid}, 32'd0);
        chk("arst_raddr", imem_raddr, RST_PC >> 2);
        chk("arst_pc", pc, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            model_check();
            cycle(1'b0, 32'h0, 1'b1);
            model_step(1'b0, 32'h0, 1'b1);
        end

        // ---------------- JAL at RESET_PC ----------------
        jal_mode = 1'b1;
        do_reset();
        cycle(1'b0, 32'h0, 1'b1);
        chk("jal_valid", {31'b0, inst_valid}, 32'd1);
        chk("jal_pc", pc, 32'h100);
        chk("jal_inst", inst, 32'h0100_006F);
        chk("jal_pred", {31'b0, pred_taken}, JAL_EN ? 32'd1 : 32'd0);
        chk("jal_raddr", imem_raddr, JAL_EN ? 32'h44 : 32'h41);
        cycle(1'b0, 32'h0, 1'b1);
        chk("jal_next_pc", pc, JAL_EN ? 32'h110 : 32'h104);
        chk("jal_next_pred", {31'b0, pred_taken}, 32'd0);
        jal_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_inst_fetch_unit
`default_nettype wire
